// File: rtl/udp_pump_req_scheduler.sv
// udp_pump_req_scheduler
// Shares the single request port of the UDP/DDR pump between NUM_REQ stream-parser requesters.
// Round-robin grant, one request in flight on the output stage at a time, a credit limit on
// requests issued to the pump but not yet completed, and a timeout that forcibly returns a
// credit if the pump stops signalling completion.
//
// Ports
//   clock, rst_n   system clock, asynchronous active-low reset
//   enable         1 = new grants allowed (a request already presented still completes)
//   req_valid      per-requester request valid
//   req_data       requester i at [i*DSIZE +: DSIZE]
//   req_ready      one-hot, single-cycle accept pulse
//   out_valid      request to pump valid
//   out_data       request word, held stable until out_ready
//   out_id         index of the requester whose word is on out_data
//   out_ready      pump accepts request
//   done           pump finished one request (1-cycle pulse)
//   outstanding    issued-but-not-done count
//   timeout_err    1-cycle pulse on forced credit release
//   underflow_err  1-cycle pulse on done while nothing is outstanding
module udp_pump_req_scheduler #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DSIZE           = 132,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT         = 1024,
  localparam int unsigned IdW            = $clog2(NUM_REQ),
  localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned TmrW           = $clog2(TIMEOUT)
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DSIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [DSIZE-1:0]         out_data,
  output logic [IdW-1:0]           out_id,
  input  logic                     out_ready,
  input  logic                     done,
  output logic [CntW-1:0]          outstanding,
  output logic                     timeout_err,
  output logic                     underflow_err
);

  // The grant phase is the single idle cycle in which req_ready fires; the word is latched on
  // that edge and presented from the next cycle, so a request occupies two cycles minimum.
  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   out_id_q, out_id_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic             timeout_err_q, underflow_err_q;

  logic             win_found;
  logic [IdW-1:0]   win_idx;
  logic [IdW:0]     scan;
  logic [DSIZE-1:0] win_data;
  logic             credit_ok, grant, hs, tmr_fire, dec, underflow;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IdW + 1)'(k);
      if (scan >= (IdW + 1)'(NUM_REQ)) begin
        scan = scan - (IdW + 1)'(NUM_REQ);
      end
      if (!win_found && req_valid[scan[IdW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IdW-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IdW'(i)) begin
        win_data = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign credit_ok = outstanding_q < CntW'(MAX_OUTSTANDING);
  assign grant     = (state_q == StIdle) && enable && credit_ok && win_found;
  assign hs        = (state_q == StSend) && out_ready;

  // Timer counts cycles with credits out and no completion; firing on its last value means
  // the release happens after exactly TIMEOUT such cycles.
  assign tmr_fire  = (outstanding_q != '0) && !done && (tmr_q == TmrW'(TIMEOUT - 1));
  // A done alongside a handshake is legal even from zero: the two cancel.
  assign underflow = done && (outstanding_q == '0) && !hs;
  assign dec       = (done && !underflow) || tmr_fire;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_id_d   = out_id_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d    = StSend;
          out_id_d   = win_idx;
          out_data_d = win_data;
        end
      end
      StSend: begin
        if (out_ready) begin
          state_d  = StIdle;
          rr_ptr_d = (out_id_q == IdW'(NUM_REQ - 1)) ? '0 : out_id_q + IdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (hs && !dec) begin
      outstanding_d = outstanding_q + CntW'(1);
    end else if (!hs && dec) begin
      outstanding_d = outstanding_q - CntW'(1);
    end
  end

  always_comb begin
    tmr_d = tmr_q + TmrW'(1);
    if (done || (outstanding_q == '0) || tmr_fire) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      out_id_q        <= '0;
      out_data_q      <= '0;
      outstanding_q   <= '0;
      tmr_q           <= '0;
      timeout_err_q   <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      out_id_q        <= out_id_d;
      out_data_q      <= out_data_d;
      outstanding_q   <= outstanding_d;
      tmr_q           <= tmr_d;
      timeout_err_q   <= tmr_fire;
      underflow_err_q <= underflow;
    end
  end

  assign req_ready     = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign out_valid     = (state_q == StSend);
  assign out_data      = out_data_q;
  assign out_id        = out_id_q;
  assign outstanding   = outstanding_q;
  assign timeout_err   = timeout_err_q;
  assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_udp_pump_req_scheduler.sv
// Bench for udp_pump_req_scheduler: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of arbitration, credits and timeout.
module tb_udp_pump_req_scheduler;

  localparam int N    = 4;
  localparam int DS   = 132;
  localparam int MAXO = 2;
  localparam int TMO  = 16;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DS-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DS-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_ready = 1'b0;
  logic            done = 1'b0;
  logic [1:0]      outstanding;
  logic            timeout_err;
  logic            underflow_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            m_busy;
  int            m_id, m_ptr, m_cnt, m_quiet;
  logic [DS-1:0] m_data;
  bit            m_tmo, m_unf;

  udp_pump_req_scheduler #(
    .NUM_REQ(N), .DSIZE(DS), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready), .done(done), .outstanding(outstanding),
    .timeout_err(timeout_err), .underflow_err(underflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_busy = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_quiet = 0;
    m_data = '0; m_tmo = 0; m_unf = 0;
  endtask

  // First requester with valid set, scanning from the round-robin pointer.
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (((req_valid >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs already driven; returns at the next one.
  task automatic cycle();
    int w;
    bit can, hs, unf, fire;
    logic [N-1:0] er;
    #1;
    w   = pick();
    can = !m_busy && enable && (m_cnt < MAXO) && (w >= 0);
    er  = can ? (N'(1) << w) : '0;
    chk("req_ready", DS'(req_ready), DS'(er));
    chk("out_valid", DS'(out_valid), DS'(m_busy));
    chk("out_id", DS'(out_id), DS'(m_id));
    chk("out_data", out_data, m_data);
    chk("outstanding", DS'(outstanding), DS'(m_cnt));
    chk("timeout_err", DS'(timeout_err), DS'(m_tmo));
    chk("underflow_err", DS'(underflow_err), DS'(m_unf));
    @(posedge clock);
    hs   = m_busy && out_ready;
    unf  = done && (m_cnt == 0) && !hs;
    fire = 0;
    if (m_cnt > 0 && !done) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        fire    = 1;
        m_quiet = 0;
      end
    end else begin
      m_quiet = 0;
    end
    m_cnt = m_cnt + (hs ? 1 : 0) - ((done && !unf) ? 1 : 0) - (fire ? 1 : 0);
    if (hs) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % N;
    end
    if (can) begin
      m_busy = 1;
      m_id   = w;
      m_data = DS'(req_data >> (w * DS));
    end
    m_tmo = fire;
    m_unf = unf;
    @(negedge clock);
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    done      = 1'b1;
    repeat (4) cycle();
    done = 1'b0;
  endtask

  initial begin
    logic [DS-1:0] d0;
    logic [1:0]    id0;
    int            grants;
    int            ids[$];

    // Reset values
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req_ready", DS'(req_ready), DS'(0));
    chk("rst_out_valid", DS'(out_valid), DS'(0));
    chk("rst_out_data", out_data, DS'(0));
    chk("rst_out_id", DS'(out_id), DS'(0));
    chk("rst_outstanding", DS'(outstanding), DS'(0));
    chk("rst_timeout_err", DS'(timeout_err), DS'(0));
    chk("rst_underflow_err", DS'(underflow_err), DS'(0));
    reset_model();
    rst_n = 1'b1;

    // T1 single requester
    enable = 1'b1; out_ready = 1'b1; req_valid = 4'b0100;
    req_data[2*DS +: DS] = 132'hA5;
    #1 chk("t1_ready", DS'(req_ready), DS'(4'b0100));
    cycle();
    req_valid = '0;
    #1;
    chk("t1_out_valid", DS'(out_valid), DS'(1));
    chk("t1_out_data", out_data, 132'hA5);
    chk("t1_out_id", DS'(out_id), DS'(2));
    cycle();
    #1 chk("t1_outstanding", DS'(outstanding), DS'(1));

    // T6 reset while a request is presented
    req_valid = '1;
    cycle();
    #1 chk("t6_pre_valid", DS'(out_valid), DS'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", DS'(out_valid), DS'(0));
    chk("t6_outstanding", DS'(outstanding), DS'(0));
    reset_model();
    @(negedge clock);
    rst_n = 1'b1;
    #1 chk("t6_first_grant", DS'(req_ready), DS'(4'b0001));

    // T2 round-robin fairness with completion after every issue
    for (int k = 0; k < 16; k++) begin
      done = (outstanding != 0);
      if (out_valid) ids.push_back(int'(out_id));
      cycle();
    end
    done = 1'b0;
    chk("t2_issue_count", DS'(ids.size()), DS'(8));
    for (int j = 0; j < ids.size() && j < 8; j++) chk("t2_order", DS'(ids[j]), DS'(j % 4));

    // T3 backpressure
    drain();
    req_valid = '1; out_ready = 1'b0;
    for (int k = 0; k < 4 && !out_valid; k++) cycle();
    chk("t3_out_valid", DS'(out_valid), DS'(1));
    d0 = out_data; id0 = out_id;
    for (int k = 0; k < 10; k++) begin
      req_valid = N'($urandom);
      req_data[k % N * DS +: 32] = $urandom;
      #1 chk("t3_no_ready", DS'(req_ready), DS'(0));
      cycle();
      chk("t3_data_stable", out_data, d0);
      chk("t3_id_stable", DS'(out_id), DS'(id0));
    end
    out_ready = 1'b1; req_valid = '0;
    cycle();
    chk("t3_released", DS'(out_valid), DS'(0));

    // T4 credit limit
    drain();
    req_valid = '1; out_ready = 1'b1; done = 1'b0; grants = 0;
    for (int k = 0; k < 8; k++) begin
      #1 if (req_ready != 0) grants++;
      cycle();
    end
    chk("t4_grants", DS'(grants), DS'(2));
    chk("t4_outstanding", DS'(outstanding), DS'(2));
    #1 chk("t4_blocked", DS'(req_ready), DS'(0));
    done = 1'b1;
    cycle();
    done = 1'b0;
    #1 chk("t4_regrant", DS'(req_ready != 0), DS'(1));
    cycle();

    // T5 timeout then underflow
    drain();
    req_valid = 4'b0010; out_ready = 1'b1;
    cycle();
    req_valid = '0;
    cycle();
    repeat (15) cycle();
    chk("t5_no_timeout_yet", DS'(timeout_err), DS'(0));
    cycle();
    chk("t5_timeout", DS'(timeout_err), DS'(1));
    chk("t5_outstanding", DS'(outstanding), DS'(0));
    done = 1'b1;
    cycle();
    done = 1'b0;
    chk("t5_underflow", DS'(underflow_err), DS'(1));

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      enable    = ($urandom_range(0, 7) != 0);
      req_valid = N'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      done      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < N * DS; b++) req_data[b] = 1'($urandom);
      end
      cycle();
    end
    done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
